// File: rtl/pf_io_dly_ctrl.sv
// Dynamic delay-line sequencer for PF_IO lanes: turns one-at-a-time tap requests into
// correctly spaced LOAD / MOVE / DIRECTION pulses and keeps a tap-count shadow per lane.
module pf_io_dly_ctrl #(
  parameter int  LANES    = 4,
  parameter int  TAP_W    = 7,
  parameter int  MAX_TAP  = 127,
  parameter int  LOAD_TAP = 1,
  parameter int  SETTLE   = 4,
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              CLK,
  input  logic              ARST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [LANE_W-1:0] REQ_LANE,
  input  logic [1:0]        REQ_OP,
  input  logic [TAP_W-1:0]  REQ_ARG,
  output logic              DONE,
  output logic [1:0]        STATUS,
  output logic [TAP_W-1:0]  TAP_VALUE,
  output logic [LANES-1:0]  TAP_KNOWN,
  output logic [LANES-1:0]  DELAY_LINE_LOAD,
  output logic [LANES-1:0]  DELAY_LINE_MOVE,
  output logic [LANES-1:0]  DELAY_LINE_DIRECTION,
  input  logic [LANES-1:0]  DELAY_LINE_OUT_OF_RANGE
);

  localparam int SET_W = $clog2(SETTLE + 1);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_INC    = 2'b01;
  localparam logic [1:0] OP_DEC    = 2'b10;
  localparam logic [1:0] OP_SET    = 2'b11;
  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_CLAMP = 2'b01;
  localparam logic [1:0] STS_OOR   = 2'b10;
  localparam logic [1:0] STS_UNK   = 2'b11;

  localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] LOAD_T   = TAP_W'(LOAD_TAP);
  localparam logic [TAP_W-1:0] ONE_T    = TAP_W'(1);
  localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE);
  localparam logic [SET_W-1:0] ONE_C    = SET_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_MOVE   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  state_e             state_q;
  logic               ready_q;
  logic               done_q;
  logic [1:0]         status_q;
  logic [1:0]         fin_status_q;
  logic [TAP_W-1:0]   tap_val_q;
  logic [LANES-1:0]   known_q;
  logic [LANES-1:0]   load_q;
  logic [LANES-1:0]   move_q;
  logic [LANES-1:0]   dir_q;
  logic [LANE_W-1:0]  lane_q;
  logic [1:0]         op_q;
  logic [TAP_W-1:0]   arg_q;
  logic [TAP_W-1:0]   rem_q;
  logic [SET_W-1:0]   cnt_q;
  logic               clamp_q;
  logic [TAP_W-1:0]   shadow_q [LANES];

  logic [TAP_W-1:0]   cur_tap_s;
  logic [TAP_W-1:0]   step_tap_s;
  logic               step_ok_s;
  logic               oor_s;
  logic               set_clamp_s;
  logic [TAP_W-1:0]   set_tgt_s;
  logic               set_up_s;
  logic [TAP_W-1:0]   set_dist_s;
  logic               fin_now_s;
  logic [1:0]         fin_status_s;

  // Step legality, SET target geometry and the single completion decision.
  always_comb begin
    cur_tap_s   = shadow_q[lane_q];
    oor_s       = DELAY_LINE_OUT_OF_RANGE[lane_q];
    if (dir_q[lane_q]) begin
      step_ok_s  = (cur_tap_s != MAX_T);
      step_tap_s = cur_tap_s + ONE_T;
    end else begin
      step_ok_s  = (cur_tap_s != '0);
      step_tap_s = cur_tap_s - ONE_T;
    end
    set_clamp_s = ({1'b0, arg_q} > {1'b0, MAX_T});
    set_tgt_s   = set_clamp_s ? MAX_T : arg_q;
    set_up_s    = (set_tgt_s > LOAD_T);
    set_dist_s  = set_up_s ? (set_tgt_s - LOAD_T) : (LOAD_T - set_tgt_s);

    fin_now_s    = 1'b0;
    fin_status_s = fin_status_q;
    if (state_q == ST_FIN) begin
      fin_now_s = 1'b1;
    end else if ((state_q == ST_MOVE) || ((state_q == ST_SETTLE) && (cnt_q == '0))) begin
      // OOR outranks a pending clamp; a blocked step ends the op with the remainder dropped.
      if ((state_q == ST_SETTLE) && oor_s) begin
        fin_now_s    = 1'b1;
        fin_status_s = STS_OOR;
      end else if ((rem_q != '0) && step_ok_s) begin
        fin_now_s    = 1'b0;
      end else begin
        fin_now_s    = 1'b1;
        fin_status_s = ((rem_q != '0) || clamp_q) ? STS_CLAMP : STS_OK;
      end
    end else begin
      fin_now_s = 1'b0;
    end
  end

  // Sequencer FSM with registered handshake, pulse and shadow state.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      status_q     <= STS_OK;
      fin_status_q <= STS_OK;
      tap_val_q    <= '0;
      known_q      <= '0;
      load_q       <= '0;
      move_q       <= '0;
      dir_q        <= '0;
      lane_q       <= '0;
      op_q         <= OP_LOAD;
      arg_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      clamp_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) shadow_q[i] <= LOAD_T;
    end else begin
      load_q <= '0;
      move_q <= '0;
      done_q <= 1'b0;
      if (fin_now_s) begin
        ready_q   <= 1'b1;
        done_q    <= 1'b1;
        status_q  <= fin_status_s;
        tap_val_q <= cur_tap_s;
        dir_q     <= '0;
        state_q   <= ST_IDLE;
        if (fin_status_s == STS_OOR) known_q[lane_q] <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (REQ_VALID) begin
              lane_q  <= REQ_LANE;
              op_q    <= REQ_OP;
              arg_q   <= REQ_ARG;
              clamp_q <= 1'b0;
              ready_q <= 1'b0;
              state_q <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            case (op_q)
              OP_LOAD: begin
                rem_q   <= '0;
                state_q <= ST_LOAD;
              end
              OP_SET: begin
                dir_q[lane_q] <= set_up_s;
                rem_q         <= set_dist_s;
                clamp_q       <= set_clamp_s;
                state_q       <= ST_LOAD;
              end
              default: begin
                dir_q[lane_q] <= (op_q == OP_INC);
                rem_q         <= arg_q;
                if (!known_q[lane_q]) begin
                  fin_status_q <= STS_UNK;
                  state_q      <= ST_FIN;
                end else if (arg_q == '0) begin
                  fin_status_q <= STS_OK;
                  state_q      <= ST_FIN;
                end else begin
                  state_q      <= ST_MOVE;
                end
              end
            endcase
          end
          ST_LOAD: begin
            load_q[lane_q]   <= 1'b1;
            shadow_q[lane_q] <= LOAD_T;
            known_q[lane_q]  <= 1'b1;
            cnt_q            <= SETTLE_C;
            state_q          <= ST_SETTLE;
          end
          ST_MOVE, ST_SETTLE: begin
            if ((state_q == ST_SETTLE) && (cnt_q != '0)) begin
              cnt_q <= cnt_q - ONE_C;
            end else begin
              move_q[lane_q]   <= 1'b1;
              shadow_q[lane_q] <= step_tap_s;
              rem_q            <= rem_q - ONE_T;
              cnt_q            <= SETTLE_C;
              state_q          <= ST_SETTLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign REQ_READY            = ready_q;
  assign DONE                 = done_q;
  assign STATUS               = status_q;
  assign TAP_VALUE            = tap_val_q;
  assign TAP_KNOWN            = known_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_pf_io_dly_ctrl.sv
// Scoreboard bench for pf_io_dly_ctrl: a behavioural tap model predicts each request's
// completion, and a pulse monitor checks timing, direction and lane isolation.
module tb_pf_io_dly_ctrl;
  localparam int LANES = 4, TAP_W = 7, MAX_TAP = 127, LOAD_TAP = 1, SETTLE = 4, LW = 2;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              req_valid;
  logic              req_ready;
  logic [LW-1:0]     req_lane;
  logic [1:0]        req_op;
  logic [TAP_W-1:0]  req_arg;
  logic              done;
  logic [1:0]        status;
  logic [TAP_W-1:0]  tap_value;
  logic [LANES-1:0]  tap_known, dl_load, dl_move, dl_dir, dl_oor;
  logic [LANES-1:0]  oor_drv, oor_static;

  assign dl_oor = oor_drv | oor_static;

  pf_io_dly_ctrl #(.LANES(LANES), .TAP_W(TAP_W), .MAX_TAP(MAX_TAP), .LOAD_TAP(LOAD_TAP),
                   .SETTLE(SETTLE)) dut (
    .CLK(clk), .ARST_N(arst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_LANE(req_lane), .REQ_OP(req_op), .REQ_ARG(req_arg), .DONE(done), .STATUS(status),
    .TAP_VALUE(tap_value), .TAP_KNOWN(tap_known), .DELAY_LINE_LOAD(dl_load),
    .DELAY_LINE_MOVE(dl_move), .DELAY_LINE_DIRECTION(dl_dir), .DELAY_LINE_OUT_OF_RANGE(dl_oor)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lane; int status; int tap; logic [LANES-1:0] known; int lat;
    int loads; int moves; int first_mv; logic dir; int acc; int oor_k;
  } exp_t;

  exp_t             sb_q[$];
  int               n_vec = 0, n_err = 0, cyc = 0;
  int               m_shadow[LANES];
  logic [LANES-1:0] m_known;
  int               mv_cnt = 0, ld_cnt = 0, tm_err = 0, stray = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: predicts completion of one request and advances the tap model.
  function automatic exp_t model(int lane, int op, int arg, int oor_k);
    exp_t e;
    int n, room, tgt;
    e.lane = lane; e.oor_k = oor_k; e.loads = 0; e.moves = 0; e.first_mv = 2;
    e.status = 0; e.lat = 2; e.dir = 1'b0; e.acc = 0;
    if (op == 0) begin
      e.loads = 1; e.lat = 3 + SETTLE;
      m_shadow[lane] = LOAD_TAP; m_known[lane] = 1'b1;
    end else if (op == 3) begin
      tgt = (arg > MAX_TAP) ? MAX_TAP : arg;
      if (arg > MAX_TAP) e.status = 1;
      e.dir = (tgt > LOAD_TAP);
      n = (tgt > LOAD_TAP) ? tgt - LOAD_TAP : LOAD_TAP - tgt;
      m_known[lane] = 1'b1;
      if (oor_k > 0 && oor_k <= n) begin n = oor_k; e.status = 2; m_known[lane] = 1'b0; end
      e.loads = 1; e.moves = n; e.first_mv = 3 + SETTLE;
      e.lat = 3 + SETTLE + n * (SETTLE + 1);
      m_shadow[lane] = e.dir ? LOAD_TAP + n : LOAD_TAP - n;
    end else begin
      e.dir = (op == 1);
      if (!m_known[lane]) e.status = 3;
      else if (arg != 0) begin
        room = (op == 1) ? MAX_TAP - m_shadow[lane] : m_shadow[lane];
        n = (arg < room) ? arg : room;
        if (n < arg) e.status = 1;
        if (oor_k > 0 && oor_k <= n) begin n = oor_k; e.status = 2; m_known[lane] = 1'b0; end
        e.moves = n; e.lat = 2 + n * (SETTLE + 1);
        m_shadow[lane] = (op == 1) ? m_shadow[lane] + n : m_shadow[lane] - n;
      end
    end
    e.tap = m_shadow[lane]; e.known = m_known;
    return e;
  endfunction

  task automatic issue(input int lane, input int op, input int arg, input int oor_k,
                       input bit hold, input bit b2b);
    exp_t e;
    int   guard = 0;
    do begin @(negedge clk); guard++; end while (!req_ready && guard < 3000);
    if (!req_ready) begin
      check_val("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (b2b) check_val("b2b_accept_in_done_cycle", done, 32'd1);
    req_lane = lane[LW-1:0]; req_op = op[1:0]; req_arg = arg[TAP_W-1:0]; req_valid = 1'b1;
    e = model(lane, op, arg, oor_k);
    e.acc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse timing, direction, lane isolation, OOR injection and DONE scoring.
  always @(negedge clk) begin
    exp_t             e;
    int               rel;
    logic [LANES-1:0] mask;
    if (!arst_n) begin
      mv_cnt = 0; ld_cnt = 0; tm_err = 0; stray = 0; oor_drv = '0;
    end else if (sb_q.size() == 0) begin
      if ((dl_load | dl_move | dl_dir) != '0) check_val("idle_pulse", dl_load | dl_move | dl_dir, 32'd0);
      if (done) check_val("unexpected_done", done, 32'd0);
    end else begin
      e = sb_q[0];
      rel = cyc - e.acc;
      if (rel >= 0) begin
        mask = LANES'(1) << e.lane;
        if (((dl_load | dl_move | dl_dir) & ~mask) != '0) stray++;
        if (dl_move[e.lane]) begin
          if (rel != e.first_mv + mv_cnt * (SETTLE + 1)) tm_err++;
          mv_cnt++;
          if (mv_cnt == e.oor_k) oor_drv[e.lane] = 1'b1;
        end
        if (dl_load[e.lane]) begin
          if (rel != 2) tm_err++;
          ld_cnt++;
        end
        if (done) begin
          check_val("status", status, e.status);
          if (e.status != 3) check_val("tap_value", tap_value, e.tap);
          check_val("tap_known", tap_known, e.known);
          check_val("done_latency", rel, e.lat);
          check_val("move_count", mv_cnt, e.moves);
          check_val("load_count", ld_cnt, e.loads);
          check_val("pulse_timing_dir", tm_err, 32'd0);
          check_val("other_lane_toggle", stray, 32'd0);
          check_val("ready_with_done", req_ready, 32'd1);
          void'(sb_q.pop_front());
          mv_cnt = 0; ld_cnt = 0; tm_err = 0; stray = 0; oor_drv = '0;
        end else if (rel >= 1 && dl_dir[e.lane] !== e.dir) begin
          tm_err++;
        end
      end
    end
  end

  initial begin
    int guard;
    req_valid = 1'b0; req_lane = '0; req_op = '0; req_arg = '0;
    oor_static = '0; oor_drv = '0; arst_n = 1'b0;
    for (int i = 0; i < LANES; i++) m_shadow[i] = LOAD_TAP;
    m_known = '0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check_val("rst_ready", req_ready, 32'd1);
    check_val("rst_done", done, 32'd0);
    check_val("rst_status", status, 32'd0);
    check_val("rst_tap_value", tap_value, 32'd0);
    check_val("rst_known", tap_known, 32'd0);
    check_val("rst_lines", {dl_load, dl_move, dl_dir}, 32'd0);

    issue(2, 0, 0, 0, 1'b0, 1'b0);            // LOAD lane 2
    issue(0, 0, 0, 0, 1'b0, 1'b0);            // LOAD lane 0
    oor_static[2] = 1'b1;                     // non-selected lane flag must be ignored
    issue(0, 1, 3, 0, 1'b0, 1'b0);            // INC 3 lane 0
    issue(3, 2, 2, 0, 1'b0, 1'b0);            // DEC 2 on unknown lane 3
    oor_static = '0;
    issue(0, 1, 0, 0, 1'b0, 1'b0);            // INC 0
    issue(1, 3, 125, 0, 1'b0, 1'b0);          // SET 125 lane 1
    issue(1, 1, 5, 0, 1'b0, 1'b0);            // INC 5 clamps at MAX_TAP
    issue(1, 2, 3, 0, 1'b0, 1'b0);            // DEC 3
    issue(1, 3, 0, 0, 1'b0, 1'b0);            // SET 0 moves downward
    issue(1, 2, 1, 0, 1'b0, 1'b0);            // DEC at 0: blocked step
    issue(1, 3, 10, 4, 1'b0, 1'b0);           // SET 10, OOR during 4th move's settle
    issue(1, 1, 1, 0, 1'b0, 1'b0);            // lane 1 now unknown
    issue(0, 0, 0, 0, 1'b0, 1'b0);
    issue(0, 1, 20, 0, 1'b0, 1'b0);           // long INC, aborted by reset
    repeat (30) @(posedge clk);
    #3 arst_n = 1'b0;
    #1;
    check_val("abort_load", dl_load, 32'd0);
    check_val("abort_move", dl_move, 32'd0);
    check_val("abort_dir", dl_dir, 32'd0);
    check_val("abort_ready", req_ready, 32'd1);
    check_val("abort_done", done, 32'd0);
    sb_q.delete();
    for (int i = 0; i < LANES; i++) m_shadow[i] = LOAD_TAP;
    m_known = '0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check_val("post_abort_known", tap_known, 32'd0);
    repeat (4) @(negedge clk);

    issue(1, 0, 0, 0, 1'b1, 1'b0);            // back-to-back with REQ_VALID held
    issue(1, 1, 2, 0, 1'b1, 1'b1);
    issue(1, 2, 1, 0, 1'b0, 1'b1);

    guard = 0;
    while (sb_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    check_val("drain", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
